// File: rtl/pipeline_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_pkg
// Shared pipeline constants: datapath width, register address width and the
// MemtoReg writeback-select encodings used by the writeback stage and the
// forwarding unit.
// -----------------------------------------------------------------------------
package pipeline_pkg;

   localparam int XLEN   = 32;
   localparam int REG_AW = 5;

   // Writeback source select carried in the MEM/WB register.
   typedef enum logic [1:0] {
      MTR_ALU  = 2'b00,
      MTR_MEM  = 2'b01,
      MTR_LINK = 2'b10,
      MTR_RSVD = 2'b11
   } mtr_sel_e;

   // True when a writeback carries load data (counts toward load profiling).
   function automatic logic is_load_wb(input logic mem_read, input logic [1:0] mtr);
      return mem_read && (mtr == MTR_MEM);
   endfunction

endpackage : pipeline_pkg

// File: rtl/wb_mux.sv
// -----------------------------------------------------------------------------
// wb_mux
// Combinational writeback selector. The reserved encoding falls back to the
// ALU result so a corrupted select never produces an undefined value.
// Shared with the forwarding unit so both see identical writeback data.
// -----------------------------------------------------------------------------
module wb_mux
   import pipeline_pkg::*;
#(
   parameter int XLEN = pipeline_pkg::XLEN
) (
   input  logic [1:0]      MemtoReg_in,
   input  logic [XLEN-1:0] Read_data_in,
   input  logic [XLEN-1:0] result_in,
   input  logic [XLEN-1:0] link_in,
   output logic [XLEN-1:0] wb_data
);

   logic [XLEN-1:0] sel_data_s;

   // Pick the writeback source; reserved and unknown selects use the ALU result.
   always_comb begin
      sel_data_s = result_in;
      case (MemtoReg_in)
         MTR_ALU:  sel_data_s = result_in;
         MTR_MEM:  sel_data_s = Read_data_in;
         MTR_LINK: sel_data_s = link_in;
         MTR_RSVD: sel_data_s = result_in;
         default:  sel_data_s = result_in;
      endcase
   end

   assign wb_data = sel_data_s;

endmodule : wb_mux

// File: rtl/wb_regfile.sv
// -----------------------------------------------------------------------------
// wb_regfile
// Writeback stage and general-purpose register file. Selects the writeback
// value from the MEM/WB fields, commits it to the register array, serves the
// two ID-stage read ports and keeps retirement / load-writeback counters.
//
// Build option: define WB_BYPASS_EN for write-first read ports (a read of the
// register being written this cycle returns the new value). Without it the
// read ports return the pre-write array contents and ID must stall.
// -----------------------------------------------------------------------------
module wb_regfile
   import pipeline_pkg::*;
#(
   parameter int XLEN = pipeline_pkg::XLEN,
   parameter int NREG = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [XLEN-1:0]   Read_data_in,
   input  logic [XLEN-1:0]   result_in,
   input  logic [XLEN-1:0]   link_in,
   input  logic [REG_AW-1:0] RtorRd_in,
   input  logic [1:0]        MemtoReg_in,
   input  logic              RegWr_in,
   input  logic              MemRead_in,
   input  logic [REG_AW-1:0] rs_addr,
   input  logic [REG_AW-1:0] rt_addr,
   output logic [XLEN-1:0]   rs_data,
   output logic [XLEN-1:0]   rt_data,
   output logic [XLEN-1:0]   wb_data_o,
   output logic [REG_AW-1:0] wb_addr_o,
   output logic              wb_en_o,
   output logic [31:0]       wb_cnt,
   output logic [31:0]       load_cnt
);

   localparam logic [REG_AW-1:0] ZERO_ADDR = {REG_AW{1'b0}};

   logic [XLEN-1:0] regs_r [NREG];
   logic [31:0]     wb_cnt_r;
   logic [31:0]     load_cnt_r;

   logic [XLEN-1:0] wb_data_s;
   logic            wb_en_s;
   logic            load_wb_s;
   logic [XLEN-1:0] rs_data_s;
   logic [XLEN-1:0] rt_data_s;

   wb_mux #(
      .XLEN (XLEN)
   ) u_wb_mux (
      .MemtoReg_in  (MemtoReg_in),
      .Read_data_in (Read_data_in),
      .result_in    (result_in),
      .link_in      (link_in),
      .wb_data      (wb_data_s)
   );

   // Commit qualifier: r0 writes are dropped and nothing commits while reset is asserted.
   always_comb begin
      wb_en_s   = 1'b0;
      load_wb_s = 1'b0;
      if (reset && RegWr_in && (RtorRd_in != ZERO_ADDR)) begin
         wb_en_s   = 1'b1;
         load_wb_s = is_load_wb(MemRead_in, MemtoReg_in);
      end else begin
         wb_en_s   = 1'b0;
         load_wb_s = 1'b0;
      end
   end

   // Register array: cleared asynchronously, written on a qualified commit.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NREG; i++) begin
            regs_r[i] <= {XLEN{1'b0}};
         end
      end else if (wb_en_s) begin
         regs_r[RtorRd_in] <= wb_data_s;
      end
   end

   // Event counters: committed writes and committed load writebacks, wrapping.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wb_cnt_r   <= 32'd0;
         load_cnt_r <= 32'd0;
      end else begin
         if (wb_en_s) begin
            wb_cnt_r <= wb_cnt_r + 32'd1;
         end
         if (load_wb_s) begin
            load_cnt_r <= load_cnt_r + 32'd1;
         end
      end
   end

   // rs read port: r0 reads zero, optional write-first bypass, else array contents.
   always_comb begin
      rs_data_s = {XLEN{1'b0}};
      if (rs_addr == ZERO_ADDR) begin
         rs_data_s = {XLEN{1'b0}};
`ifdef WB_BYPASS_EN
      end else if (wb_en_s && (rs_addr == RtorRd_in)) begin
         rs_data_s = wb_data_s;
`endif
      end else begin
         rs_data_s = regs_r[rs_addr];
      end
   end

   // rt read port: same rules as rs.
   always_comb begin
      rt_data_s = {XLEN{1'b0}};
      if (rt_addr == ZERO_ADDR) begin
         rt_data_s = {XLEN{1'b0}};
`ifdef WB_BYPASS_EN
      end else if (wb_en_s && (rt_addr == RtorRd_in)) begin
         rt_data_s = wb_data_s;
`endif
      end else begin
         rt_data_s = regs_r[rt_addr];
      end
   end

   assign rs_data   = rs_data_s;
   assign rt_data   = rt_data_s;
   assign wb_data_o = wb_data_s;
   assign wb_addr_o = RtorRd_in;
   assign wb_en_o   = wb_en_s;
   assign wb_cnt    = wb_cnt_r;
   assign load_cnt  = load_cnt_r;

endmodule : wb_regfile

// File: tb/tb_wb_regfile.sv
// -----------------------------------------------------------------------------
// tb_wb_regfile
// Directed and randomized stimulus for wb_regfile, checked against a simple
// array/counter reference model held in the bench.
// -----------------------------------------------------------------------------
module tb_wb_regfile;

   logic        clk;
   logic        reset;
   logic [31:0] Read_data_in;
   logic [31:0] result_in;
   logic [31:0] link_in;
   logic [4:0]  RtorRd_in;
   logic [1:0]  MemtoReg_in;
   logic        RegWr_in;
   logic        MemRead_in;
   logic [4:0]  rs_addr;
   logic [4:0]  rt_addr;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic [31:0] wb_data_o;
   logic [4:0]  wb_addr_o;
   logic        wb_en_o;
   logic [31:0] wb_cnt;
   logic [31:0] load_cnt;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model state.
   logic [31:0] mdl_regs [32];
   logic [31:0] mdl_wb;
   logic [31:0] mdl_ld;

   wb_regfile dut (
      .clk          (clk),
      .reset        (reset),
      .Read_data_in (Read_data_in),
      .result_in    (result_in),
      .link_in      (link_in),
      .RtorRd_in    (RtorRd_in),
      .MemtoReg_in  (MemtoReg_in),
      .RegWr_in     (RegWr_in),
      .MemRead_in   (MemRead_in),
      .rs_addr      (rs_addr),
      .rt_addr      (rt_addr),
      .rs_data      (rs_data),
      .rt_data      (rt_data),
      .wb_data_o    (wb_data_o),
      .wb_addr_o    (wb_addr_o),
      .wb_en_o      (wb_en_o),
      .wb_cnt       (wb_cnt),
      .load_cnt     (load_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected writeback value from the select rules.
   function automatic logic [31:0] exp_wb();
      if (MemtoReg_in == 2'b01) return Read_data_in;
      if (MemtoReg_in == 2'b10) return link_in;
      return result_in;
   endfunction

   function automatic logic exp_en();
      return reset && RegWr_in && (RtorRd_in != 5'd0);
   endfunction

   // Expected read-port value for the current inputs.
   function automatic logic [31:0] exp_rd(input logic [4:0] a);
      if (a == 5'd0) return 32'd0;
`ifdef WB_BYPASS_EN
      if (exp_en() && (a == RtorRd_in)) return exp_wb();
`endif
      return mdl_regs[a];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag);
      chk({tag, ".wb_data"},  wb_data_o, exp_wb());
      chk({tag, ".wb_addr"},  {27'd0, wb_addr_o}, {27'd0, RtorRd_in});
      chk({tag, ".wb_en"},    {31'd0, wb_en_o}, {31'd0, exp_en()});
      chk({tag, ".rs"},       rs_data, exp_rd(rs_addr));
      chk({tag, ".rt"},       rt_data, exp_rd(rt_addr));
      chk({tag, ".wb_cnt"},   wb_cnt, mdl_wb);
      chk({tag, ".load_cnt"}, load_cnt, mdl_ld);
   endtask

   // Advance one rising edge, apply the commit rules to the model, then settle.
   task automatic tick();
      @(posedge clk);
      if (exp_en()) begin
         mdl_regs[RtorRd_in] = exp_wb();
         mdl_wb = mdl_wb + 32'd1;
         if (MemRead_in && (MemtoReg_in == 2'b01)) mdl_ld = mdl_ld + 32'd1;
      end
      #1;
   endtask

   task automatic mdl_clear();
      for (int i = 0; i < 32; i++) mdl_regs[i] = 32'd0;
      mdl_wb = 32'd0;
      mdl_ld = 32'd0;
   endtask

   task automatic drive(input logic we, input logic [4:0] rd, input logic [1:0] mtr,
                        input logic mr, input logic [31:0] res, input logic [31:0] rdat,
                        input logic [31:0] lk);
      RegWr_in     = we;
      RtorRd_in    = rd;
      MemtoReg_in  = mtr;
      MemRead_in   = mr;
      result_in    = res;
      Read_data_in = rdat;
      link_in      = lk;
   endtask

   task automatic drive_random();
      drive(1'($urandom), 5'($urandom), 2'($urandom), 1'($urandom),
            $urandom, $urandom, $urandom);
      rs_addr = 5'($urandom);
      rt_addr = ($urandom_range(0, 3) == 0) ? rs_addr : 5'($urandom);
   endtask

   initial begin
      logic [31:0] ldv;
      mdl_clear();
      reset   = 1'b0;
      rs_addr = 5'd5;
      rt_addr = 5'd0;
      drive(1'b1, 5'd5, 2'b00, 1'b0, 32'h1234_5678, 32'd0, 32'd0);

      // Reset held for three edges with a write pending.
      repeat (3) tick();
      chk_all("reset_hold");
      @(negedge clk);
      reset = 1'b1;
      drive(1'b0, 5'd5, 2'b00, 1'b0, 32'd0, 32'd0, 32'd0);
      #1;
      chk_all("reset_release");

      // Writeback select over all four encodings into r8.
      rs_addr = 5'd8;
      rt_addr = 5'd8;
      for (int m = 0; m < 4; m++) begin
         @(negedge clk);
         drive(1'b1, 5'd8, 2'(m), 1'b0, 32'h11, 32'h22, 32'h33);
         #1;
         chk_all("sel_pre");
         tick();
         chk_all("sel_post");
      end
      chk("sel_r8_last", mdl_regs[8], 32'h11);
      chk("sel_wb_cnt4", wb_cnt, 32'd4);

      // Writes to r0 are dropped.
      @(negedge clk);
      drive(1'b1, 5'd0, 2'b00, 1'b0, 32'hDEAD_BEEF, 32'd0, 32'd0);
      rs_addr = 5'd0;
      #1;
      chk_all("zero_pre");
      tick();
      chk_all("zero_post");
      chk("zero_cnt", wb_cnt, 32'd4);

      // Bypass: r3 = 5, then write 0xA while reading r3 in the same cycle.
      @(negedge clk);
      drive(1'b1, 5'd3, 2'b00, 1'b0, 32'h5, 32'd0, 32'd0);
      tick();
      @(negedge clk);
      drive(1'b1, 5'd3, 2'b00, 1'b0, 32'hA, 32'd0, 32'd0);
      rs_addr = 5'd3;
      rt_addr = 5'd3;
      #1;
`ifdef WB_BYPASS_EN
      chk("bypass_same_cycle", rs_data, 32'hA);
`else
      chk("readold_same_cycle", rs_data, 32'h5);
`endif
      chk_all("bypass_pre");
      tick();
      @(negedge clk);
      RegWr_in = 1'b0;
      #1;
      chk("bypass_next_cycle", rs_data, 32'hA);

      // Counter wrap with a committed load.
      force dut.wb_cnt_r = 32'hFFFF_FFFF;
      #1;
      release dut.wb_cnt_r;
      mdl_wb = 32'hFFFF_FFFF;
      #1;
      chk("force_wb_cnt", wb_cnt, 32'hFFFF_FFFF);
      ldv = $urandom;
      drive(1'b1, 5'd4, 2'b01, 1'b1, 32'd0, ldv, 32'd0);
      rs_addr = 5'd4;
      tick();
      chk("wrap_wb_cnt", wb_cnt, 32'd0);
      chk("wrap_load_cnt", load_cnt, 32'd1);
      chk_all("wrap_post");

      // Randomized stream.
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         drive_random();
         #1;
         chk_all("rand_pre");
         tick();
         chk_all("rand_post");
      end

      // Asynchronous reset between edges during a write stream.
      @(negedge clk);
      drive(1'b1, 5'd9, 2'b10, 1'b0, 32'd0, 32'd0, 32'h4444_0000);
      tick();
      #2;
      reset = 1'b0;
      mdl_clear();
      #1;
      for (int a = 0; a < 32; a++) begin
         rs_addr = 5'(a);
         rt_addr = 5'(31 - a);
         #1;
         chk("async_rs", rs_data, 32'd0);
         chk("async_rt", rt_data, 32'd0);
      end
      chk_all("async_cnt");

      // Release between edges; the first commit lands on the next rising edge.
      @(negedge clk);
      reset = 1'b1;
      drive(1'b1, 5'd7, 2'b00, 1'b0, 32'h7777_7777, 32'd0, 32'd0);
      rs_addr = 5'd7;
      rt_addr = 5'd9;
      #1;
      chk_all("rel_pre");
      tick();
      chk_all("rel_post");
      chk("rel_wb_cnt", wb_cnt, 32'd1);
      @(negedge clk);
      RegWr_in = 1'b0;
      #1;
      chk("rel_r7", rs_data, 32'h7777_7777);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_wb_regfile
